xgmii_tx_arbiter: RTL and testbench

//  Shares one XGMII TX interface among PORTS frame sources. Each source presents pre-encoded XGMII words.

---
 rtl/xgmii_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_xgmii_tx_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_arbiter.sv
// xgmii_tx_arbiter: round-robin frame arbiter sharing one XGMII TX link, with idle-word inter-frame gap.
// Optional frame-length watchdog enabled by defining XGMII_ARB_WATCHDOG_EN.
module xgmii_tx_arbiter #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH/8,
   parameter int PORTS           = 2,
   parameter int IFG_WORDS       = 2,
   parameter int MAX_FRAME_WORDS = 256
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORTS-1:0]                 s_req,
   input  logic [PORTS*DATA_WIDTH-1:0]      s_xgmii_d,
   input  logic [PORTS*CTRL_WIDTH-1:0]      s_xgmii_c,
   output logic [PORTS-1:0]                 s_grant,
   output logic [PORTS-1:0]                 s_ready,
   output logic [DATA_WIDTH-1:0]            xgmii_d,
   output logic [CTRL_WIDTH-1:0]            xgmii_c,
   input  logic                             xgmii_clk_en,
   output logic                             busy,
   output logic                             wdog_trip
);
   localparam int PW = PORTS > 1 ? $clog2(PORTS) : 1;
   localparam int IW = IFG_WORDS > 1 ? $clog2(IFG_WORDS) : 1;
   localparam logic [DATA_WIDTH-1:0] IDLE_D  = {CTRL_WIDTH{8'h07}};
   localparam logic [DATA_WIDTH-1:0] ABORT_D = {{(CTRL_WIDTH-2){8'h07}}, 8'hFD, 8'hFE};
   typedef enum logic [1:0] {IDLE, XFER, IFG} state_t;
   state_t                r_state;
   logic [PW-1:0]         r_rr;
   logic [PW-1:0]         r_gidx;
   logic [IW-1:0]         r_ifg;
   logic                  w_found;
   logic [PW-1:0]         w_win;
   logic [PW-1:0]         w_idx;
   logic                  w_term;
   logic                  w_abort;
   logic                  w_xfer;
   logic [DATA_WIDTH-1:0] w_d;
   logic [CTRL_WIDTH-1:0] w_c;
   assign w_xfer  = xgmii_clk_en && r_state == XFER && !w_abort;
   assign s_ready = w_xfer ? s_grant : '0;
   assign busy    = r_state != IDLE;
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      w_d     = '0;
      w_c     = '0;
      w_term  = 1'b0;
      for (int k = 0; k < PORTS; k++) begin
         w_idx = PW'((int'(r_rr) + k) % PORTS);
         if (!w_found && s_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
         if (r_gidx == PW'(k)) begin
            w_d = s_xgmii_d[k*DATA_WIDTH +: DATA_WIDTH];
            w_c = s_xgmii_c[k*CTRL_WIDTH +: CTRL_WIDTH];
         end
      end
      for (int k = 0; k < CTRL_WIDTH; k++)
         w_term = w_term | (w_c[k] && w_d[8*k +: 8] == 8'hFD);
   end
`ifdef XGMII_ARB_WATCHDOG_EN
   localparam int CW = $clog2(MAX_FRAME_WORDS + 1);
   logic [CW-1:0] r_wcnt;
   always_ff @(posedge clk) begin
      if (rst || r_state != XFER)
         r_wcnt <= '0;
      else if (xgmii_clk_en)
         r_wcnt <= r_wcnt + 1'b1;
   end
   // The abort cycle replaces the MAX_FRAME_WORDS-th word, which stays with the source
   assign w_abort = r_state == XFER && r_wcnt == CW'(MAX_FRAME_WORDS - 1);
`else
   assign w_abort = MAX_FRAME_WORDS < 0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_rr      <= '0;
         r_gidx    <= '0;
         r_ifg     <= '0;
         s_grant   <= '0;
         xgmii_d   <= IDLE_D;
         xgmii_c   <= '1;
         wdog_trip <= 1'b0;
      end else if (xgmii_clk_en) begin
         xgmii_d   <= IDLE_D;
         xgmii_c   <= '1;
         wdog_trip <= 1'b0;
         case (r_state)
            IDLE: if (w_found) begin
               s_grant <= PORTS'(1) << w_win;
               r_gidx  <= w_win;
               r_rr    <= w_win == PW'(PORTS - 1) ? '0 : w_win + 1'b1;
               r_state <= XFER;
            end
            XFER: if (w_abort) begin
               xgmii_d   <= ABORT_D;
               wdog_trip <= 1'b1;
               s_grant   <= '0;
               r_ifg     <= IW'(IFG_WORDS - 1);
               r_state   <= IFG_WORDS == 0 ? IDLE : IFG;
            end else begin
               xgmii_d <= w_d;
               xgmii_c <= w_c;
               if (w_term) begin
                  s_grant <= '0;
                  r_ifg   <= IW'(IFG_WORDS - 1);
                  r_state <= IFG_WORDS == 0 ? IDLE : IFG;
               end
            end
            default: begin
               if (r_ifg == '0)
                  r_state <= IDLE;
               else
                  r_ifg <= r_ifg - 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// tb_xgmii_tx_arbiter: directed and randomized frame traffic checked against a frame-schedule model.
// Define XGMII_ARB_WATCHDOG_EN to exercise the watchdog build with an 8-word limit.
module tb_xgmii_tx_arbiter;
   localparam int P   = 3;
   localparam int IFG = 2;
`ifdef XGMII_ARB_WATCHDOG_EN
   localparam bit WD   = 1'b1;
   localparam int MAXW = 8;
`else
   localparam bit WD   = 1'b0;
   localparam int MAXW = 256;
`endif
   localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
   localparam logic [63:0] ABORT_W = 64'h070707070707FDFE;
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [P-1:0]   s_req = '0;
   logic [P*64-1:0] s_xgmii_d = '0;
   logic [P*8-1:0] s_xgmii_c = '0;
   logic [P-1:0]   s_grant, s_ready;
   logic [63:0]    xgmii_d;
   logic [7:0]     xgmii_c;
   logic           xgmii_clk_en = 1'b1;
   logic           busy, wdog_trip;
   int checks = 0;
   int failures = 0;
   logic [71:0] q[P][$];
   logic [P-1:0] drop = '0;
   int en_mode = 0;
   int owner, fr_end, arb_at, en_cnt, rr;
   bit ab, exp_trip;
   logic [71:0] exp_q[$];
   logic [63:0] exp_d;
   logic [7:0]  exp_c;

   xgmii_tx_arbiter #(.PORTS(P), .IFG_WORDS(IFG), .MAX_FRAME_WORDS(MAXW)) dut (
      .clk(clk), .rst(rst), .s_req(s_req), .s_xgmii_d(s_xgmii_d), .s_xgmii_c(s_xgmii_c),
      .s_grant(s_grant), .s_ready(s_ready), .xgmii_d(xgmii_d), .xgmii_c(xgmii_c),
      .xgmii_clk_en(xgmii_clk_en), .busy(busy), .wdog_trip(wdog_trip));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_term(input logic [71:0] w);
      for (int k = 0; k < 8; k++)
         if (w[64+k] && w[8*k +: 8] == 8'hFD) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int frame_len(input int p);
      for (int i = 0; i < q[p].size(); i++)
         if (is_term(q[p][i])) return i + 1;
      return 1 << 20;
   endfunction

   function automatic logic [P-1:0] onehot(input int p);
      logic [P-1:0] one = 1;
      return p < 0 ? '0 : one << p;
   endfunction

   task automatic add_frame(input int p, input int len);
      int lane = $urandom_range(0, 7);
      logic [63:0] d;
      logic [7:0] c;
      q[p].push_back({8'h01, $urandom, $urandom_range(0, 32'hFFFFFF), 8'hFB});
      for (int i = 1; i < len - 1; i++)
         q[p].push_back({8'h00, i == 1 ? 64'hFDFDFDFDFDFDFDFD : {$urandom, $urandom}});
      for (int k = 0; k < 8; k++) begin
         d[8*k +: 8] = k < lane ? 8'($urandom) : k == lane ? 8'hFD : 8'h07;
         c[k] = k >= lane;
      end
      q[p].push_back({c, d});
   endtask

   task automatic model_reset();
      owner = -1; arb_at = 0; en_cnt = 0; rr = 0; ab = 0;
      exp_q.delete(); exp_d = IDLE_W; exp_c = 8'hFF; exp_trip = 0;
      for (int p = 0; p < P; p++) q[p].delete();
      drop = '0;
   endtask

   task automatic model_step(input logic [P-1:0] req);
      int n, w, len;
      en_cnt++;
      n = en_cnt;
      exp_trip = 0;
      if (owner >= 0) begin
         if (ab && n == fr_end) begin
            exp_d = ABORT_W; exp_c = 8'hFF; exp_trip = 1;
            q[owner].delete();
            owner = -1; arb_at = n + IFG + 1;
         end else begin
            {exp_c, exp_d} = exp_q.pop_front();
            if (n == fr_end) begin owner = -1; arb_at = n + IFG + 1; end
         end
      end else begin
         exp_d = IDLE_W; exp_c = 8'hFF;
         if (n >= arb_at && req != '0) begin
            w = -1;
            for (int k = 0; k < P; k++)
               if (w < 0 && req[(rr + k) % P]) w = (rr + k) % P;
            owner = w; rr = (w + 1) % P;
            len = frame_len(w);
            ab = WD && len >= MAXW;
            fr_end = n + (ab ? MAXW : len);
            exp_q.delete();
            for (int i = 0; i < (ab ? MAXW - 1 : len) && i < q[w].size(); i++)
               exp_q.push_back(q[w][i]);
         end
      end
   endtask

   task automatic check_outputs();
      chk("xgmii_d", xgmii_d, exp_d);
      chk("xgmii_c", 64'(xgmii_c), 64'(exp_c));
      chk("s_grant", 64'(s_grant), 64'(onehot(owner)));
      chk("busy", 64'(busy), 64'(owner >= 0 || en_cnt < arb_at - 1));
      chk("wdog_trip", 64'(wdog_trip), 64'(exp_trip));
   endtask

   task automatic tick();
      logic [P-1:0] req, rdy, exp_rdy;
      bit en;
      xgmii_clk_en = en_mode == 0 ? 1'b1 : en_mode == 1 ? ~xgmii_clk_en : ($urandom_range(0, 3) != 0);
      for (int p = 0; p < P; p++) begin
         s_req[p] = q[p].size() != 0 && !drop[p];
         s_xgmii_d[p*64 +: 64] = q[p].size() != 0 ? q[p][0][63:0] : {$urandom, $urandom};
         s_xgmii_c[p*8 +: 8]   = q[p].size() != 0 ? q[p][0][71:64] : 8'($urandom);
      end
      @(negedge clk);
      en = xgmii_clk_en;
      req = s_req;
      exp_rdy = (en && owner >= 0 && !(ab && en_cnt + 1 == fr_end)) ? onehot(owner) : '0;
      chk("s_ready", 64'(s_ready), 64'(exp_rdy));
      rdy = s_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < P; p++)
         if (rdy[p] && q[p].size() != 0) void'(q[p].pop_front());
      if (en) model_step(req);
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_req = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_outputs();
   endtask

   function automatic bit pending();
      bit r = owner >= 0;
      for (int p = 0; p < P; p++) r |= q[p].size() != 0;
      return r;
   endfunction

   task automatic drain();
      int t = 0;
      while (pending() && t < 1000) begin tick(); t++; end
      repeat (IFG + 2) tick();
      chk("drain_done", 64'(pending()), 64'd0);
   endtask

   initial begin
      do_reset();
      do_reset();
      // idle link with no requests
      repeat (10) tick();
      // single frame, then back-to-back sources across the gap
      add_frame(0, 4);
      drain();
      add_frame(0, 4);
      add_frame(1, 3);
      drain();
      // two continuously requesting sources alternate
      repeat (2) begin add_frame(0, 3); add_frame(1, 3); end
      drain();
      // clock enable toggling mid-frame
      en_mode = 1;
      add_frame(0, 5);
      add_frame(2, 4);
      drain();
      en_mode = 0;
      // request dropped mid-frame keeps the grant
      add_frame(1, 6);
      for (int t = 0; t < 50 && owner != 1; t++) tick();
      drop[1] = 1'b1;
      for (int t = 0; t < 50 && owner == 1; t++) tick();
      drop = '0;
      drain();
      // reset in the middle of a frame
      add_frame(0, 8);
      for (int t = 0; t < 50 && owner != 0; t++) tick();
      repeat (3) tick();
      do_reset();
      repeat (3) tick();
      // over-long frame
      if (WD) begin
         q[0].push_back({8'h01, 56'h55555555555555, 8'hFB});
         for (int i = 0; i < 9; i++) q[0].push_back({8'h00, $urandom, $urandom});
      end else
         add_frame(0, 20);
      add_frame(1, 3);
      drain();
      // randomized traffic with random clock enable
      en_mode = 2;
      for (int t = 0; t < 400; t++) begin
         int p = $urandom_range(0, P - 1);
         if ($urandom_range(0, 7) == 0 && q[p].size() < 20) add_frame(p, $urandom_range(2, 6));
         tick();
      end
      drain();
      en_mode = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
